// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Request fields are sized for the widest supported configuration (32-bit address/data).
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts ACCESS cycles and flags the last allowed one.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (en && cnt_q != LIMIT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (instruction fetch / data) in front of a single memory access unit.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise data wins ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_done,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_done,
    output logic [DATA_W-1:0] data_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              memory_read_enable,
    output logic              memory_write_enable,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] memory_write_data,
    input  logic [DATA_W-1:0] memory_read_data,
    input  logic              memory_read_data_valid,
    input  logic              memory_write_done
);

    arb_state_t        state_q, state_d;
    arb_req_t          req_q, req_d;
    logic              port_q, port_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              fetch_done_q, fetch_done_d;
    logic              data_done_q, data_done_d;
    logic              winner;
    logic              grant;
    logic              wd_clear;
    logic              wd_expired;
    logic              complete;

    assign grant = (state_q == ARB_IDLE) && (fetch_req || data_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        if (fetch_req && data_req)
            winner = ~last_grant_q;
        else
            winner = data_req ? PORT_DATA : PORT_FETCH;
        last_grant_d = grant ? winner : last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_grant_q <= PORT_DATA;
        else
            last_grant_q <= last_grant_d;
    end
`else
    assign winner = data_req ? PORT_DATA : PORT_FETCH;
`endif

    assign complete = req_q.we ? memory_write_done : memory_read_data_valid;

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        port_d       = port_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        fetch_done_d = 1'b0;
        data_done_d  = 1'b0;
        wd_clear     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    state_d  = ARB_ACCESS;
                    port_d   = winner;
                    wd_clear = 1'b1;
                    if (winner == PORT_DATA) begin
                        req_d.we    = data_we;
                        req_d.addr  = ARB_ADDR_W'(data_addr);
                        req_d.wdata = ARB_DATA_W'(data_wdata);
                    end else begin
                        req_d.we    = 1'b0;
                        req_d.addr  = ARB_ADDR_W'(fetch_addr);
                        req_d.wdata = '0;
                    end
                    mem_re_d = ~req_d.we;
                    mem_we_d = req_d.we;
                end
            end
            ARB_ACCESS: begin
                // A completion on the expiry edge still counts as success.
                if (complete || wd_expired) begin
                    state_d      = ARB_RESP;
                    err_d        = ~complete;
                    rdata_d      = (complete && !req_q.we) ? memory_read_data : '0;
                    fetch_done_d = (port_q == PORT_FETCH);
                    data_done_d  = (port_q == PORT_DATA);
                end else begin
                    mem_re_d = ~req_q.we;
                    mem_we_d = req_q.we;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            req_q        <= '0;
            port_q       <= PORT_FETCH;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            port_q       <= port_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            fetch_done_q <= fetch_done_d;
            data_done_q  <= data_done_d;
        end
    end

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .en     (state_q == ARB_ACCESS),
        .expired(wd_expired)
    );

    assign busy                = (state_q != ARB_IDLE);
    assign fetch_done          = fetch_done_q;
    assign data_done           = data_done_q;
    assign fetch_rdata         = rdata_q;
    assign data_rdata          = rdata_q;
    assign rsp_err             = err_q;
    assign memory_read_enable  = mem_re_q;
    assign memory_write_enable = mem_we_q;
    assign memory_address      = req_q.addr[ADDR_W-1:0];
    assign memory_write_data   = req_q.wdata[DATA_W-1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a programmable-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_done;
    logic [31:0] fetch_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_done;
    logic [31:0] data_rdata;
    logic        rsp_err;
    logic        busy;
    logic        memory_read_enable;
    logic        memory_write_enable;
    logic [31:0] memory_address;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;
    logic        memory_read_data_valid;
    logic        memory_write_done;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_done(data_done), .data_rdata(data_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .memory_read_enable(memory_read_enable), .memory_write_enable(memory_write_enable),
        .memory_address(memory_address), .memory_write_data(memory_write_data),
        .memory_read_data(memory_read_data), .memory_read_data_valid(memory_read_data_valid),
        .memory_write_done(memory_write_done)
    );

    // Memory model: answers in the (mem_wait+1)-th enabled cycle; mem_wait < 0 never answers.
    int          mem_wait = 0;
    int          en_cnt = 0;
    logic [31:0] mem_val = '0;
    logic        stray_wd = 1'b0;
    logic        stray_rv = 1'b0;
    logic        resp;

    always @(negedge clk)
        en_cnt = (memory_read_enable || memory_write_enable) ? en_cnt + 1 : 0;

    assign resp                   = (mem_wait >= 0) && (en_cnt == mem_wait + 1);
    assign memory_read_data_valid = (resp && memory_read_enable) || stray_rv;
    assign memory_write_done      = (resp && memory_write_enable) || stray_wd;
    assign memory_read_data       = mem_val;

    typedef struct {
        logic        port;
        logic        err;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          en;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic        obs_port, obs_err, obs_we;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    int          obs_en, obs_cyc;

    task automatic wait_done(input int budget, output bit got);
        int n = 0;
        got = 0;
        obs_en = 0;
        while (!got && n < budget) begin
            @(negedge clk);
            n++;
            if (memory_read_enable || memory_write_enable) begin
                if (obs_en == 0) begin
                    obs_addr  = memory_address;
                    obs_we    = memory_write_enable;
                    obs_wdata = memory_write_data;
                end
                obs_en++;
            end
            if (fetch_done || data_done) begin
                got       = 1;
                obs_port  = data_done;
                obs_rdata = data_done ? data_rdata : fetch_rdata;
                obs_err   = rsp_err;
            end
        end
        obs_cyc = n;
    endtask

    task automatic do_reset;
        fetch_req = 0; data_req = 0; reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset;
        bit got;
        exp_t e;
        fetch_req = 1; data_req = 1; data_we = 0;
        fetch_addr = 32'h10; data_addr = 32'h20;
        mem_wait = 0; mem_val = 32'h0BAD_F00D; reset = 1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({fetch_done, data_done, rsp_err, busy, memory_read_enable, memory_write_enable,
             memory_address, memory_write_data, fetch_rdata, data_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b re=%b we=%b addr=%h wdata=%h done=%b%b, all zero required",
                     busy, memory_read_enable, memory_write_enable, memory_address,
                     memory_write_data, fetch_done, data_done);
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        e = '{port: 1'b0, err: 1'b0, we: 1'b0, addr: 32'h10, wdata: '0, rdata: 32'h0BAD_F00D, en: 1};
`else
        e = '{port: 1'b1, err: 1'b0, we: 1'b0, addr: 32'h20, wdata: '0, rdata: 32'h0BAD_F00D, en: 1};
`endif
        sb.push_back(e);
        reset = 0;
        @(negedge clk);
        n_vec++;
        if ({busy, memory_read_enable, memory_address} !== {2'b11, e.addr}) begin
            n_err++;
            $display("FAIL first_grant: busy=%b re=%b addr=%h, want 1 1 %h",
                     busy, memory_read_enable, memory_address, e.addr);
        end
        wait_done(10, got);
        fetch_req = 0; data_req = 0;
        e = sb.pop_front();
        n_vec++;
        if (!got || {obs_port, obs_err, obs_rdata} !== {e.port, e.err, e.rdata}) begin
            n_err++;
            $display("FAIL reset_first_txn: got=%0b port=%b err=%b rdata=%h, want port=%b err=%b rdata=%h",
                     got, obs_port, obs_err, obs_rdata, e.port, e.err, e.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_fetch_read;
        bit got;
        exp_t e;
        fetch_addr = 32'h100; mem_wait = 2; mem_val = 32'hDEAD_BEEF;
        sb.push_back('{port: 1'b0, err: 1'b0, we: 1'b0, addr: 32'h100, wdata: '0, rdata: 32'hDEAD_BEEF, en: 3});
        fetch_req = 1;
        wait_done(20, got);
        fetch_req = 0;
        e = sb.pop_front();
        n_vec++;
        if (!got || {obs_port, obs_err, obs_we, obs_addr, obs_rdata} !== {e.port, e.err, e.we, e.addr, e.rdata}) begin
            n_err++;
            $display("FAIL fetch_read: got=%0b port=%b err=%b we=%b addr=%h rdata=%h, want %b %b %b %h %h",
                     got, obs_port, obs_err, obs_we, obs_addr, obs_rdata, e.port, e.err, e.we, e.addr, e.rdata);
        end
        n_vec++;
        if (obs_en != e.en) begin
            n_err++;
            $display("FAIL fetch_read_enable_cycles: got %0d want %0d", obs_en, e.en);
        end
        @(negedge clk);
        n_vec++;
        if ({busy, fetch_done, data_done} !== 3'b000) begin
            n_err++;
            $display("FAIL fetch_read_idle: busy=%b done=%b%b, want 0 00", busy, fetch_done, data_done);
        end
    endtask

    task automatic test_back_to_back;
        bit got;
        exp_t e;
        mem_wait = 0; mem_val = 32'h1111_2222;
        data_we = 0; data_addr = 32'h44;
        sb.push_back('{port: 1'b1, err: 1'b0, we: 1'b0, addr: 32'h44, wdata: '0, rdata: 32'h1111_2222, en: 1});
        sb.push_back('{port: 1'b1, err: 1'b0, we: 1'b0, addr: 32'h48, wdata: '0, rdata: 32'h3333_4444, en: 1});
        data_req = 1;
        for (int k = 0; k < 2; k++) begin
            wait_done(10, got);
            e = sb.pop_front();
            n_vec++;
            if (!got || obs_cyc != (k == 0 ? 2 : 3) || obs_en != e.en) begin
                n_err++;
                $display("FAIL b2b_latency[%0d]: got=%0b cycles=%0d en=%0d, want cycles=%0d en=%0d",
                         k, got, obs_cyc, obs_en, (k == 0 ? 2 : 3), e.en);
            end
            n_vec++;
            if ({obs_port, obs_err, obs_addr, obs_rdata} !== {e.port, e.err, e.addr, e.rdata}) begin
                n_err++;
                $display("FAIL b2b_txn[%0d]: port=%b err=%b addr=%h rdata=%h, want %b %b %h %h",
                         k, obs_port, obs_err, obs_addr, obs_rdata, e.port, e.err, e.addr, e.rdata);
            end
            data_addr = 32'h48;
            mem_val   = 32'h3333_4444;
            if (k == 1) data_req = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_tie;
        bit got;
        bit keep_f, keep_d;
        exp_t e;
        exp_t ef, ed;
        do_reset();
        ef = '{port: 1'b0, err: 1'b0, we: 1'b0, addr: 32'h200, wdata: '0, rdata: 32'h1234, en: 2};
        ed = '{port: 1'b1, err: 1'b0, we: 1'b1, addr: 32'h40, wdata: 32'h55, rdata: '0, en: 2};
`ifdef MEM_ARB_ROUND_ROBIN_EN
        sb.push_back(ef); sb.push_back(ed); sb.push_back(ef); sb.push_back(ed);
`else
        sb.push_back(ed); sb.push_back(ef);
`endif
        fetch_addr = 32'h200; data_addr = 32'h40; data_we = 1; data_wdata = 32'h55;
        mem_val = 32'h1234; mem_wait = 1;
        fetch_req = 1; data_req = 1;
        while (sb.size() > 0) begin
            wait_done(20, got);
            e = sb.pop_front();
            n_vec++;
            if (!got || {obs_port, obs_err, obs_we, obs_addr} !== {e.port, e.err, e.we, e.addr} ||
                obs_en != e.en) begin
                n_err++;
                $display("FAIL tie_order: got=%0b port=%b err=%b we=%b addr=%h en=%0d, want %b %b %b %h %0d",
                         got, obs_port, obs_err, obs_we, obs_addr, obs_en, e.port, e.err, e.we, e.addr, e.en);
                fetch_req = 0; data_req = 0;
                sb.delete();
                break;
            end
            n_vec++;
            if (e.we ? (obs_wdata !== e.wdata) : (obs_rdata !== e.rdata)) begin
                n_err++;
                $display("FAIL tie_data: port=%b wdata=%h rdata=%h, want wdata=%h rdata=%h",
                         obs_port, obs_wdata, obs_rdata, e.wdata, e.rdata);
            end
            keep_f = 0; keep_d = 0;
            foreach (sb[i]) begin
                if (sb[i].port) keep_d = 1; else keep_f = 1;
            end
            if (!keep_f) fetch_req = 0;
            if (!keep_d) data_req = 0;
        end
        fetch_req = 0; data_req = 0; data_we = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        bit got;
        exp_t e;
        fetch_addr = 32'h300; mem_wait = -1; mem_val = 32'hCAFE_F00D;
        sb.push_back('{port: 1'b0, err: 1'b1, we: 1'b0, addr: 32'h300, wdata: '0, rdata: '0, en: 4});
        fetch_req = 1;
        wait_done(20, got);
        fetch_req = 0;
        e = sb.pop_front();
        n_vec++;
        if (!got || {obs_port, obs_err, obs_addr, obs_rdata} !== {e.port, e.err, e.addr, e.rdata} ||
            obs_en != e.en) begin
            n_err++;
            $display("FAIL timeout: got=%0b port=%b err=%b addr=%h rdata=%h en=%0d, want %b %b %h %h %0d",
                     got, obs_port, obs_err, obs_addr, obs_rdata, obs_en, e.port, e.err, e.addr, e.rdata, e.en);
        end
        @(negedge clk);
        n_vec++;
        if ({busy, rsp_err, fetch_done} !== 3'b000) begin
            n_err++;
            $display("FAIL timeout_idle: busy=%b err=%b done=%b, want 000", busy, rsp_err, fetch_done);
        end
        // Completion on the very edge the watchdog expires.
        data_we = 0; data_addr = 32'h304; mem_wait = 3;
        sb.push_back('{port: 1'b1, err: 1'b0, we: 1'b0, addr: 32'h304, wdata: '0, rdata: 32'hCAFE_F00D, en: 4});
        data_req = 1;
        wait_done(20, got);
        data_req = 0;
        e = sb.pop_front();
        n_vec++;
        if (!got || {obs_port, obs_err, obs_rdata} !== {e.port, e.err, e.rdata} || obs_en != e.en) begin
            n_err++;
            $display("FAIL timeout_tie_success: got=%0b port=%b err=%b rdata=%h en=%0d, want %b %b %h %0d",
                     got, obs_port, obs_err, obs_rdata, obs_en, e.port, e.err, e.rdata, e.en);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        bit got;
        bit saw_done;
        exp_t e;
        data_we = 1; data_addr = 32'h80; data_wdata = 32'h77; mem_wait = -1;
        data_req = 1;
        @(negedge clk);
        n_vec++;
        if ({memory_write_enable, memory_address} !== {1'b1, 32'h80}) begin
            n_err++;
            $display("FAIL midreset_access: we=%b addr=%h, want 1 00000080", memory_write_enable, memory_address);
        end
        @(negedge clk);
        reset = 1; data_req = 0; data_we = 0;
        @(negedge clk);
        reset = 0;
        n_vec++;
        if ({memory_read_enable, memory_write_enable, busy, fetch_done, data_done} !== 5'b0) begin
            n_err++;
            $display("FAIL midreset_drop: re=%b we=%b busy=%b done=%b%b, want all 0",
                     memory_read_enable, memory_write_enable, busy, fetch_done, data_done);
        end
        saw_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (fetch_done || data_done) saw_done = 1;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_done: saw done pulse, want none");
        end
        fetch_addr = 32'h500; mem_wait = 0; mem_val = 32'h5555_AAAA;
        sb.push_back('{port: 1'b0, err: 1'b0, we: 1'b0, addr: 32'h500, wdata: '0, rdata: 32'h5555_AAAA, en: 1});
        fetch_req = 1;
        wait_done(10, got);
        fetch_req = 0;
        e = sb.pop_front();
        n_vec++;
        if (!got || {obs_port, obs_err, obs_addr, obs_rdata} !== {e.port, e.err, e.addr, e.rdata}) begin
            n_err++;
            $display("FAIL midreset_recover: got=%0b port=%b err=%b addr=%h rdata=%h, want %b %b %h %h",
                     got, obs_port, obs_err, obs_addr, obs_rdata, e.port, e.err, e.addr, e.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_stray;
        stray_wd = 1;
        @(negedge clk);
        stray_wd = 0;
        stray_rv = 1;
        n_vec++;
        if ({busy, fetch_done, data_done, rsp_err} !== 4'b0) begin
            n_err++;
            $display("FAIL stray_write_done: busy=%b done=%b%b err=%b, want 0000",
                     busy, fetch_done, data_done, rsp_err);
        end
        @(negedge clk);
        stray_rv = 0;
        n_vec++;
        if ({busy, fetch_done, data_done, memory_read_enable} !== 4'b0) begin
            n_err++;
            $display("FAIL stray_read_valid: busy=%b done=%b%b re=%b, want 0000",
                     busy, fetch_done, data_done, memory_read_enable);
        end
        @(negedge clk);
        n_vec++;
        if ({busy, fetch_done, data_done} !== 3'b0) begin
            n_err++;
            $display("FAIL stray_settle: busy=%b done=%b%b, want 000", busy, fetch_done, data_done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_fetch_read();
        test_back_to_back();
        test_tie();
        test_timeout();
        test_reset_mid_access();
        test_stray();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
